// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: W-stage, LU result, issue and GRF write-port signals
//   slave  : arbiter side (takes W/LU/issue, drives grf_*, lu_ready, pending, stall_req)
//   master : environment side (pipeline, LU, decode, GRF)
interface wb_port_arbiter_if;
  logic        RegWrite_W;
  logic [4:0]  A3_W;
  logic [31:0] WD_W;
  logic [31:0] PC4_W;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_a3;
  logic [31:0] lu_wd;
  logic [31:0] lu_pc4;
  logic        issue_valid;
  logic [4:0]  issue_a3;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc4;
  logic [31:0] pending;
  logic        stall_req;
  modport slave (
    input  RegWrite_W, A3_W, WD_W, PC4_W, lu_valid, lu_a3, lu_wd, lu_pc4, issue_valid, issue_a3,
    output lu_ready, grf_we, grf_a3, grf_wd, grf_pc4, pending, stall_req
  );
  modport master (
    output RegWrite_W, A3_W, WD_W, PC4_W, lu_valid, lu_a3, lu_wd, lu_pc4, issue_valid, issue_a3,
    input  lu_ready, grf_we, grf_a3, grf_wd, grf_pc4, pending, stall_req
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the GRF write port between the W stage (priority) and a FIFO of LU results
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : W-stage inputs, LU result push, issue scoreboard set, GRF write port, pending, stall_req
module wb_port_arbiter #(
  parameter int DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic reset,
  wb_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int AW = $clog2(STARVE_LIMIT + 1);
  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc4;
  } ent_t;
  ent_t           mem_q [DEPTH];
  ent_t           head;
  logic [PW-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]    cnt_q, cnt_d;
  logic [AW-1:0]  age_q, age_d;
  logic [31:0]    pend_q, pend_d, set_m, clr_m;
  logic           w_act, nonempty, pop, push, aged;
  assign head      = mem_q[rd_q];
  assign nonempty  = cnt_q != '0;
  assign w_act     = bus.RegWrite_W & (bus.A3_W != 5'd0);
  assign pop       = ~w_act & nonempty;
  assign push      = bus.lu_valid & bus.lu_ready;
  assign aged      = age_q >= AW'(STARVE_LIMIT);
  assign bus.lu_ready  = cnt_q < (PW+1)'(DEPTH);
  assign bus.stall_req = nonempty & aged;
  assign bus.pending   = pend_q;
  // A popped head with a3=0 is discarded: it uses the slot but never writes.
  assign bus.grf_we  = w_act | (pop & (head.a3 != 5'd0));
  assign bus.grf_a3  = w_act ? bus.A3_W : pop ? head.a3 : 5'd0;
  assign bus.grf_wd  = w_act ? bus.WD_W : pop ? head.wd : 32'd0;
  assign bus.grf_pc4 = pop ? head.pc4 : bus.PC4_W;
  always_comb begin
    rd_d  = pop ? rd_q + PW'(1) : rd_q;
    wr_d  = push ? wr_q + PW'(1) : wr_q;
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    age_d = (pop | ~nonempty) ? '0 : aged ? age_q : age_q + AW'(1);
    set_m = (bus.issue_valid & (bus.issue_a3 != 5'd0)) ? 32'd1 << bus.issue_a3 : 32'd0;
    clr_m = (pop & (head.a3 != 5'd0)) ? 32'd1 << head.a3 : 32'd0;
    // Set is applied after clear so a newly issued op on the same register stays outstanding.
    pend_d = ((pend_q & ~clr_m) | set_m) & 32'hFFFF_FFFE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      age_q  <= '0;
      pend_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      age_q  <= age_d;
      pend_q <= pend_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= '{a3: bus.lu_a3, wd: bus.lu_wd, pc4: bus.lu_pc4};
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: randomized stimulus against a queue-based reference model of the write-port arbiter
module tb_wb_port_arbiter;
  localparam int DEPTH = 2;
  localparam int STARVE_LIMIT = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  wb_port_arbiter_if bus ();
  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc4;
  } ent_t;
  ent_t        q[$];
  int          age;
  logic [31:0] pend;
  logic        stall_prev;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    logic        w;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd, pc4;
    w = bus.RegWrite_W && bus.A3_W != 0;
    we = 0; a3 = 0; wd = 0; pc4 = bus.PC4_W;
    if (w) begin
      we = 1; a3 = bus.A3_W; wd = bus.WD_W;
    end else if (q.size() > 0) begin
      we = q[0].a3 != 0; a3 = q[0].a3; wd = q[0].wd; pc4 = q[0].pc4;
    end
    chk("lu_ready", 32'(bus.lu_ready), 32'(q.size() < DEPTH));
    chk("stall_req", 32'(bus.stall_req), 32'(q.size() > 0 && age >= STARVE_LIMIT));
    chk("grf_we", 32'(bus.grf_we), 32'(we));
    chk("grf_a3", 32'(bus.grf_a3), 32'(a3));
    chk("grf_wd", bus.grf_wd, wd);
    chk("grf_pc4", bus.grf_pc4, pc4);
    chk("pending", bus.pending, pend);
  endtask
  task automatic model_step();
    ent_t h;
    bit   w, was_empty, popped, pushed;
    w = bus.RegWrite_W && bus.A3_W != 0;
    was_empty = q.size() == 0;
    popped = !w && !was_empty;
    pushed = bus.lu_valid && q.size() < DEPTH;
    stall_prev = !was_empty && age >= STARVE_LIMIT;
    if (popped) begin
      h = q.pop_front();
      if (h.a3 != 0) pend[h.a3] = 1'b0;
    end
    if (pushed) q.push_back('{a3: bus.lu_a3, wd: bus.lu_wd, pc4: bus.lu_pc4});
    if (bus.issue_valid && bus.issue_a3 != 0) pend[bus.issue_a3] = 1'b1;
    age = (popped || was_empty) ? 0 : (age + 1 > STARVE_LIMIT ? STARVE_LIMIT : age + 1);
  endtask
  task automatic model_clear();
    q.delete();
    age = 0;
    pend = 0;
    stall_prev = 0;
  endtask
  function automatic logic [4:0] rnd_reg();
    return $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom_range(1, 31));
  endfunction
  initial begin
    int rw_pct;
    bus.RegWrite_W = 0; bus.A3_W = 0; bus.WD_W = 0; bus.PC4_W = 0;
    bus.lu_valid = 0; bus.lu_a3 = 0; bus.lu_wd = 0; bus.lu_pc4 = 0;
    bus.issue_valid = 0; bus.issue_a3 = 0;
    model_clear();
    repeat (3) @(negedge clk);
    #1 check_all();
    @(negedge clk);
    reset = 1'b1;
    rw_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i % 150 == 0) rw_pct = (i / 150) % 3 == 0 ? 95 : (i / 150) % 3 == 1 ? 60 : 20;
      bus.RegWrite_W = stall_prev && $urandom_range(0, 9) < 8 ? 1'b0 : 1'($urandom_range(0, 99) < rw_pct);
      bus.A3_W = rnd_reg();
      bus.WD_W = $urandom;
      bus.PC4_W = $urandom;
      bus.lu_valid = 1'($urandom_range(0, 1));
      bus.lu_a3 = rnd_reg();
      bus.lu_wd = $urandom;
      bus.lu_pc4 = $urandom;
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_a3 = $urandom_range(0, 1) ? bus.lu_a3 : rnd_reg();
      #1 check_all();
      if (i % 400 == 399) begin
        #2 reset = 1'b0;
        #1 model_clear();
        check_all();
        @(negedge clk);
        bus.lu_valid = 0;
        bus.issue_valid = 0;
        reset = 1'b1;
      end else model_step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single GRF write port between the pipeline W stage and a long-latency result source (multi-cycle mult/div or slow-memory return unit), called LU below.
- The W stage always has priority. LU results wait in a small FIFO and drain into idle write cycles.
- A per-register pending scoreboard lets decode stall on registers with an outstanding LU write.
- An age counter raises a pipeline-bubble request so LU results are never starved.

Parameters:
- DEPTH, 2: LU result FIFO entries (power of 2, ≥2).
- STARVE_LIMIT, 4: cycles a FIFO head may wait before stall_req asserts.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- RegWrite_W  in  1  W-stage write enable.
- A3_W  in  5  W-stage destination register.
- WD_W  in  32  W-stage write data.
- PC4_W  in  32  W-stage PC+4, for the write log.
- lu_valid  in  1  LU result offered.
- lu_ready  out  1  FIFO can accept.
- lu_a3  in  5  LU destination register.
- lu_wd  in  32  LU result data.
- lu_pc4  in  32  PC+4 of the issuing instruction.
- issue_valid  in  1  LU op issued this cycle.
- issue_a3  in  5  destination of the issued op.
- grf_we  out  1  GRF write enable.
- grf_a3  out  5  GRF write address.
- grf_wd  out  32  GRF write data.
- grf_pc4  out  32  PC+4 of the committed write.
- pending  out  32  bit r set = LU write to $r outstanding.
- stall_req  out  1  request a W-stage bubble next cycle.

Behaviour:
Reset (reset=0, asynchronous):
- FIFO count, read pointer, write pointer, age and pending all clear to 0.
- During and after reset: lu_ready=1, stall_req=0, pending=0. grf_* follow the W-stage inputs because the FIFO is empty.

Grant, combinational per cycle:
- Pipeline active (w_act) = RegWrite_W & (A3_W≠0).
- If w_act: grf_we=1; grf_a3/wd/pc4 come from the W inputs; FIFO holds.
- Else if count>0: FIFO head is popped. grf_we=(head.a3≠0); grf_a3/wd/pc4 come from the head. A head with a3=0 is popped and discarded.
- Else: grf_we=0, grf_a3=0, grf_wd=0, grf_pc4=PC4_W.
- RegWrite_W=1 with A3_W=0 counts as no pipeline write; the port is free for the FIFO.

FIFO:
- lu_ready = (count<DEPTH). It depends only on registered count, not on a same-cycle pop.
- Push on lu_valid&lu_ready, at the clock edge. Simultaneous push and pop: count unchanged, pointers both advance.
- No bypass: a result pushed at edge N reaches grf_* no earlier than cycle N+1.
- Order is strictly FIFO. Pointers wrap modulo DEPTH.

Starvation guard:
- age increments each cycle that count>0 and no pop occurs. It saturates at STARVE_LIMIT and clears to 0 on any pop or when the FIFO is empty.
- stall_req = (count>0) & (age≥STARVE_LIMIT).
- The hazard unit responds by inserting a W bubble the following cycle; the head drains then.
- stall_req deasserts combinationally in the cycle after the pop, once age is cleared.

Pending scoreboard:
- Set bit issue_a3 on issue_valid with issue_a3≠0.
- Clear bit head.a3 on a pop with head.a3≠0.
- Same cycle, same register, set and clear together: set wins (a newer op is outstanding).
- Bit 0 is always 0.
- W-stage writes never modify pending; decode must stall on pending bits to avoid WAW/RAW hazards.

Test Plan:
1. Reset mid-operation: FIFO count=2, pending=0x0000_0300, drop reset=0 → immediately count=0, pending=0, lu_ready=1, stall_req=0; the old entries never appear on grf_*.
2. Idle drain: issue_valid a3=8; next cycle lu_valid a3=8 wd=0x1234_5678, RegWrite_W=0 → the following cycle grf_we=1, grf_a3=8, grf_wd=0x1234_5678, pending[8] clears at that edge.
3. Priority: FIFO holds a3=9; RegWrite_W=1 A3_W=4 WD_W=0xAA for 3 cycles → grf_a3=4 each cycle, FIFO held, age=3; W idle on cycle 4 → $9 written.
4. Starvation: continuous W writes with one FIFO entry, STARVE_LIMIT=4 → stall_req=1 from cycle 5; bubble inserted → head written, stall_req=0 the next cycle.
5. Full/simultaneous: fill 2 entries → lu_ready=0 and an offered lu_valid is not accepted. Then pop with lu_valid in the same cycle → lu_ready stays 0 that cycle; next cycle lu_ready=1 and the push is accepted in order.
6. $0 and set/clear race: LU result a3=0 → popped, grf_we=0. Pop of a3=5 coinciding with issue a3=5 → pending[5] stays 1.
